// File: rtl/alarme_cinto_multi.sv
// Multi-seat seat-belt warning: grace delay, blinking lamp, bounded chime, offending-seat mask.
// Optional ALARME_CINTO_REARM_EN: a newly offending seat re-arms the chime within an episode.
module alarme_cinto_multi #(
  parameter int unsigned N_SEATS    = 4,
  parameter int unsigned DELAY_CYC  = 8,
  parameter int unsigned BLINK_HALF = 4,
  parameter int unsigned CHIME_MAX  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               igni,
  input  logic [N_SEATS-1:0] ocupado,
  input  logic [N_SEATS-1:0] cinto,
  output logic               luz,
  output logic               chime,
  output logic [N_SEATS-1:0] assento_alerta,
  output logic [1:0]         estado
);

  localparam int unsigned GW = $clog2(DELAY_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam int unsigned CW = $clog2(CHIME_MAX + 1);
  localparam logic [GW-1:0] G_LAST = GW'(DELAY_CYC - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHIME_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRACE = 2'd1,
    WARN  = 2'd2,
    MUTE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               luz_n, chime_n;
  logic [N_SEATS-1:0] mask_n;
  logic [GW-1:0]      gcnt, gcnt_n;
  logic [BW-1:0]      bcnt, bcnt_n;
  logic [CW-1:0]      ccnt, ccnt_n;
  logic [N_SEATS-1:0] v;
  logic               viol;

  assign v      = ocupado & ~cinto;
  assign viol   = igni & (|v);
  assign estado = state;

  always_comb begin
    state_n = state;
    luz_n   = luz;
    chime_n = chime;
    mask_n  = assento_alerta;
    gcnt_n  = gcnt;
    bcnt_n  = bcnt;
    ccnt_n  = ccnt;
    case (state)
      IDLE: begin
        luz_n   = 1'b0;
        chime_n = 1'b0;
        mask_n  = '0;
        gcnt_n  = '0;
        bcnt_n  = '0;
        ccnt_n  = '0;
        if (viol) state_n = GRACE;
      end
      GRACE: begin
        if (!viol) begin
          state_n = IDLE;
          gcnt_n  = '0;
        end else if (gcnt == G_LAST) begin
          state_n = WARN;
          gcnt_n  = '0;
          luz_n   = 1'b1;
          chime_n = 1'b1;
          bcnt_n  = '0;
          ccnt_n  = '0;
          mask_n  = v;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: begin // WARN, MUTE
        if (!viol) begin
          state_n = IDLE;
          luz_n   = 1'b0;
          chime_n = 1'b0;
          mask_n  = '0;
          bcnt_n  = '0;
          ccnt_n  = '0;
        end else begin
          mask_n = v;
          // lamp phase runs independently of WARN/MUTE so muting never disturbs the blink
          if (bcnt == B_LAST) begin
            luz_n  = ~luz;
            bcnt_n = '0;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
          if (state == WARN) begin
            if (ccnt == C_LAST) begin
              state_n = MUTE;
              chime_n = 1'b0;
            end else begin
              ccnt_n = ccnt + 1'b1;
            end
          end
`ifdef ALARME_CINTO_REARM_EN
          if (|(v & ~assento_alerta)) begin
            state_n = WARN;
            chime_n = 1'b1;
            ccnt_n  = '0;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      luz            <= 1'b0;
      chime          <= 1'b0;
      assento_alerta <= '0;
      gcnt           <= '0;
      bcnt           <= '0;
      ccnt           <= '0;
    end else begin
      state          <= state_n;
      luz            <= luz_n;
      chime          <= chime_n;
      assento_alerta <= mask_n;
      gcnt           <= gcnt_n;
      bcnt           <= bcnt_n;
      ccnt           <= ccnt_n;
    end
  end

endmodule

// File: tb/tb_alarme_cinto_multi.sv
// Scoreboard bench for alarme_cinto_multi: driver pushes model expectations, monitor compares.
module tb_alarme_cinto_multi;

  localparam int N  = 4;
  localparam int DL = 8;
  localparam int BH = 4;
  localparam int CM = 32;
`ifdef ALARME_CINTO_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         igni = 1'b0;
  logic [N-1:0] ocupado = '0;
  logic [N-1:0] cinto = '0;
  logic         luz, chime;
  logic [N-1:0] assento_alerta;
  logic [1:0]   estado;

  alarme_cinto_multi #(
    .N_SEATS(N), .DELAY_CYC(DL), .BLINK_HALF(BH), .CHIME_MAX(CM)
  ) dut (
    .clk(clk), .rst(rst), .igni(igni), .ocupado(ocupado), .cinto(cinto),
    .luz(luz), .chime(chime), .assento_alerta(assento_alerta), .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         luz;
    logic         chime;
    logic [N-1:0] mask;
    logic [1:0]   estado;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model: violation run length, time in alarm, chime cycles left
  bit           alarm = 0;
  int           run = 0;
  int           age = 0;
  int           left = 0;
  logic [N-1:0] mmask = '0;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.luz    = alarm && ((age / BH) % 2 == 0);
    e.chime  = alarm && (left > 0);
    e.mask   = alarm ? mmask : '0;
    e.estado = !alarm ? ((run > 0) ? 2'd1 : 2'd0) : ((left > 0) ? 2'd2 : 2'd3);
    return e;
  endfunction

  task automatic model_reset();
    alarm = 0; run = 0; age = 0; left = 0; mmask = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] vv, newly;
    bit viol;
    if (rst) begin
      model_reset();
    end else begin
      vv   = ocupado & ~cinto;
      viol = igni && (vv != '0);
      if (!viol) begin
        model_reset();
      end else if (!alarm) begin
        run++;
        if (run > DL) begin
          alarm = 1; age = 0; left = CM; mmask = vv;
        end
      end else begin
        newly = vv & ~mmask;
        age++;
        if (REARM && newly != '0) left = CM;
        else if (left > 0) left--;
        mmask = vv;
      end
    end
    q.push_back(model_out());
  endtask

  task automatic drive(input bit r, input bit ig, input logic [N-1:0] oc,
                       input logic [N-1:0] ci, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = r; igni = ig; ocupado = oc; cinto = ci;
      model_step();
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_luz", luz, 0);
    check("async_chime", chime, 0);
    check("async_mask", assento_alerta, 0);
    check("async_estado", estado, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("luz", luz, e.luz);
        check("chime", chime, e.chime);
        check("mask", assento_alerta, e.mask);
        check("estado", estado, e.estado);
      end
    end
  end

  initial begin : stim
    logic [N-1:0] oc, ci;
    bit ig;
    int idx;
    drive(1, 0, 4'b0000, 4'b0000, 2);
    // driver unbelted: full episode into MUTE, then buckles
    drive(0, 1, 4'b0001, 4'b0000, 45);
    drive(0, 1, 4'b0001, 4'b0001, 2);
    // buckled during grace
    drive(0, 1, 4'b0001, 4'b0000, 5);
    drive(0, 1, 4'b0001, 4'b0001, 3);
    // ignition dropout in MUTE restarts the grace delay
    drive(0, 1, 4'b0001, 4'b0000, 45);
    drive(0, 0, 4'b0001, 4'b0000, 1);
    drive(0, 1, 4'b0001, 4'b0000, 12);
    drive(0, 1, 4'b0001, 4'b0001, 1);
    // async reset mid-WARN
    drive(0, 1, 4'b0001, 4'b0000, 15);
    pulse_rst();
    drive(1, 1, 4'b0001, 4'b0000, 1);
    drive(0, 1, 4'b0001, 4'b0000, 3);
    drive(0, 1, 4'b0001, 4'b0001, 1);
    // two seats, one buckles, other vacates
    drive(0, 1, 4'b0101, 4'b0000, 45);
    drive(0, 1, 4'b0101, 4'b0001, 3);
    drive(0, 1, 4'b0001, 4'b0001, 3);
    // new offender in MUTE
    drive(0, 1, 4'b0001, 4'b0000, 45);
    drive(0, 1, 4'b0011, 4'b0000, 40);
    drive(0, 0, 4'b0011, 4'b0000, 2);
    // randomized traffic
    oc = 4'b0001; ci = 4'b0000; ig = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) begin idx = $urandom_range(0, N-1); ci[idx] = ~ci[idx]; end
      if ($urandom_range(0, 23) == 0) begin idx = $urandom_range(0, N-1); oc[idx] = ~oc[idx]; end
      if ($urandom_range(0, 99) == 0) ig = ~ig;
      if ($urandom_range(0, 599) == 0) begin
        pulse_rst();
        drive(1, ig, oc, ci, 1);
      end else begin
        drive(0, ig, oc, ci, 1);
      end
    end
    drive(0, 0, 4'b0000, 4'b0000, 2);
    @(posedge clk);
    #2;
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarme_cinto_multi.md
Name: alarme_cinto_multi

Overview:
- Sequential, parametrised successor of the single-seat seat-belt warning logic.
- Monitors N seats (occupancy + belt) under ignition. Applies a grace delay, then blinks the warning light, sounds a chime for a bounded time and reports which seats are offending.
- Sits between the cabin sensor inputs and the dashboard lamp/buzzer drivers.

Parameters:
- N_SEATS, 4, number of monitored seats (1..16); seat 0 is the driver.
- DELAY_CYC, 8, grace cycles of continuous violation before warning (>=1).
- BLINK_HALF, 4, cycles per lamp half-period (on, then off) (>=1).
- CHIME_MAX, 32, cycles the chime sounds per warning episode (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- igni  in  1  ignition on.
- ocupado  in  N_SEATS  seat i occupied.
- cinto  in  N_SEATS  seat i belt fastened.
- luz  out  1  warning lamp, registered.
- chime  out  1  buzzer enable, registered.
- assento_alerta  out  N_SEATS  offending-seat mask, registered.
- estado  out  2  FSM state: IDLE=0, GRACE=1, WARN=2, MUTE=3.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high.
  - rst asserted at any time, including mid-GRACE or mid-WARN: estado=IDLE, luz=0, chime=0, assento_alerta=0, all counters=0, immediately and without a clock.
  - First evaluation happens on the first rising edge after rst deasserts.
- Violation vector: v = ocupado & ~cinto, combinational. viol = igni & |v.
- All outputs and state are registered; inputs are sampled on the rising clk edge.
- Counters:
  - gcnt is $clog2(DELAY_CYC+1) bits.
  - bcnt is $clog2(BLINK_HALF+1) bits.
  - ccnt is $clog2(CHIME_MAX+1) bits.
  - No counter wraps; each saturates or reloads exactly as stated below.
- IDLE: luz=0, chime=0, assento_alerta=0. If viol, go to GRACE with gcnt=0.
- GRACE: outputs stay 0.
  - !viol: go to IDLE.
  - viol and gcnt==DELAY_CYC-1: go to WARN.
  - Otherwise gcnt++.
  - Net effect: violation first sampled at edge k gives luz=1 after edge k+DELAY_CYC.
- WARN: entered with luz=1, chime=1, bcnt=0, ccnt=0.
  - Lamp: bcnt counts 0..BLINK_HALF-1. When it hits BLINK_HALF-1, luz toggles and bcnt=0. This gives a period of 2*BLINK_HALF, starting with the on phase.
  - Chime: ccnt++ each cycle. When ccnt==CHIME_MAX-1, go to MUTE and chime=0, so chime is high for exactly CHIME_MAX cycles.
  - assento_alerta is loaded with v every cycle.
- MUTE: luz keeps blinking with its phase uninterrupted, chime=0, assento_alerta=v each cycle.
- Exit to IDLE: from WARN or MUTE, !viol (all offending belts fastened, seats vacated, or igni=0) means next edge IDLE, all outputs 0.
- A violation that reappears after that exit restarts the full grace delay.
- Simultaneous events:
  - igni falling in the same cycle as any other event: IDLE wins.
  - rst overrides everything.
- A seat changing from offending to compliant while another seat remains offending does not leave WARN/MUTE; only the mask updates.

Optional Feature:
- Macro: ALARME_CINTO_REARM_EN.
- Defined: in WARN or MUTE, a seat newly offending (v & ~assento_alerta nonzero) does the following at the next edge:
  - reloads ccnt=0 and forces chime=1;
  - puts the FSM in WARN;
  - leaves the lamp phase unchanged.
- Not defined: new offending seats only update assento_alerta; the chime is never re-armed within an episode.

Test Plan (defaults):
1. Driver sits unbelted: igni=1, ocupado=0001, cinto=0000 at edge k -> estado=1 after edge k, luz=1 and chime=1 after edge k+8, luz toggles every 4 cycles, chime=0 and estado=3 after edge k+40, assento_alerta=0001.
2. Belt buckled during grace: violation at edge k, cinto=0001 before edge k+5 -> estado=0 after edge k+5, luz never asserted.
3. igni=0 for one cycle while in MUTE -> all outputs 0 and estado=0 next edge. Re-asserting igni with the same violation -> luz=1 only 9 edges later.
4. Async reset: pulse rst between edges in WARN -> luz, chime, assento_alerta and estado 0 immediately. First rising edge after release with violation present -> estado=1.
5. Two seats: seats 0 and 2 unbelted in MUTE, seat 0 buckles -> estado stays 3, assento_alerta=0100. Seat 2 vacates -> IDLE.
6. Rearm, with ALARME_CINTO_REARM_EN defined: in MUTE with mask 0001, seat 1 becomes unbelted -> chime=1 for 32 cycles, mask 0011, lamp phase continuous. Without the macro -> chime stays 0, mask 0011.
